// File: rtl/hamming_pkg.sv
// Shared types and elaboration-time helpers for the extended-Hamming (SECDED) decoder.
// Position numbering: bit 0 is overall parity, powers of two are Hamming parity.
package hamming_pkg;

  typedef enum logic [1:0] {CLEAN, CORRECTED, UNCORRECTABLE} status_e;

  function automatic int N(input int p);
    return 1 << p;
  endfunction

  function automatic int K(input int p);
    return (1 << p) - p - 1;
  endfunction

  function automatic bit is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Data bit idx lives at the idx-th non-power-of-two position counted from 3 upward.
  function automatic int data_pos(input int idx);
    int cnt;
    int pos;
    int result;
    cnt    = 0;
    pos    = 3;
    result = 0;
    while (cnt <= idx) begin
      if (!is_pow2(pos)) begin
        if (cnt == idx) result = pos;
        cnt++;
      end
      pos++;
    end
    return result;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome (XOR of set-bit indices 1..N-1) and overall parity of a codeword.
module hamming_syndrome
  import hamming_pkg::*;
#(
  parameter int P_BITS = 3
) (
  input  logic [N(P_BITS)-1:0] code_i,
  output logic [P_BITS-1:0]    syn_o,
  output logic                 par_o
);

  localparam int CW = N(P_BITS);

  always_comb begin
    syn_o = '0;
    for (int i = 1; i < CW; i++) begin
      if (code_i[i]) syn_o = syn_o ^ P_BITS'(i);
    end
  end

  assign par_o = ^code_i;

endmodule

// File: rtl/hamming_secded_stream.sv
// Two-stage valid/ready SECDED decoder with saturating error counters.
// Counters are built only when HAMMING_ERR_CNT_EN is defined; otherwise they read 0.
module hamming_secded_stream
  import hamming_pkg::*;
#(
  parameter int P_BITS = 3,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N(P_BITS)-1:0] in_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [K(P_BITS)-1:0] out_data,
  output logic [P_BITS-1:0]    out_syndrome,
  output logic                 out_corrected,
  output logic                 out_uncorrectable,
  input  logic                 cnt_clear,
  output logic [CNT_W-1:0]     cnt_corr,
  output logic [CNT_W-1:0]     cnt_uncorr
);

  localparam int CW = N(P_BITS);
  localparam int DW = K(P_BITS);

  logic [P_BITS-1:0] synComb;
  logic              parComb;

  logic              s1Valid_q;
  logic [CW-1:0]     s1Code_q;
  logic [P_BITS-1:0] s1Syn_q;
  logic              s1Par_q;

  logic              outValid_q;
  logic [DW-1:0]     outData_q;
  logic [DW-1:0]     outData_d;
  logic [P_BITS-1:0] outSyn_q;
  logic              outCorr_q;
  logic              outUncorr_q;

  status_e           status_d;
  logic [CW-1:0]     fixedCode;
  logic              s2Adv;
  logic              s1Adv;

  hamming_syndrome #(.P_BITS(P_BITS)) uSyndrome (
    .code_i (in_code),
    .syn_o  (synComb),
    .par_o  (parComb)
  );

  assign s2Adv    = ~outValid_q | out_ready;
  assign s1Adv    = ~s1Valid_q | s2Adv;
  assign in_ready = s1Adv;

  // Odd parity means exactly one flip at position syn (bit 0 when syn is zero).
  always_comb begin
    status_d  = CLEAN;
    fixedCode = s1Code_q;
    if (s1Par_q) begin
      status_d            = CORRECTED;
      fixedCode[s1Syn_q]  = ~s1Code_q[s1Syn_q];
    end else if (s1Syn_q != '0) begin
      status_d = UNCORRECTABLE;
    end
  end

  for (genvar g = 0; g < DW; g++) begin : gExtract
    localparam int POS = data_pos(g);
    assign outData_d[g] = fixedCode[POS];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Code_q  <= '0;
      s1Syn_q   <= '0;
      s1Par_q   <= 1'b0;
    end else if (s1Adv) begin
      s1Valid_q <= in_valid;
      if (in_valid) begin
        s1Code_q <= in_code;
        s1Syn_q  <= synComb;
        s1Par_q  <= parComb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid_q  <= 1'b0;
      outData_q   <= '0;
      outSyn_q    <= '0;
      outCorr_q   <= 1'b0;
      outUncorr_q <= 1'b0;
    end else if (s2Adv) begin
      outValid_q <= s1Valid_q;
      if (s1Valid_q) begin
        outData_q   <= outData_d;
        outSyn_q    <= s1Syn_q;
        outCorr_q   <= (status_d == CORRECTED);
        outUncorr_q <= (status_d == UNCORRECTABLE);
      end
    end
  end

  assign out_valid         = outValid_q;
  assign out_data          = outData_q;
  assign out_syndrome      = outSyn_q;
  assign out_corrected     = outCorr_q;
  assign out_uncorrectable = outUncorr_q;

`ifdef HAMMING_ERR_CNT_EN
  logic [CNT_W-1:0] cntCorr_q;
  logic [CNT_W-1:0] cntUncorr_q;
  logic             outHs;

  assign outHs = outValid_q & out_ready;

  // Clear wins over a coincident increment; all-ones is sticky until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cntCorr_q   <= '0;
      cntUncorr_q <= '0;
    end else if (cnt_clear) begin
      cntCorr_q   <= '0;
      cntUncorr_q <= '0;
    end else if (outHs) begin
      if (outCorr_q && !(&cntCorr_q))     cntCorr_q   <= cntCorr_q + CNT_W'(1);
      if (outUncorr_q && !(&cntUncorr_q)) cntUncorr_q <= cntUncorr_q + CNT_W'(1);
    end
  end

  assign cnt_corr   = cntCorr_q;
  assign cnt_uncorr = cntUncorr_q;
`else
  logic unusedCntClear;

  assign unusedCntClear = cnt_clear;
  assign cnt_corr       = '0;
  assign cnt_uncorr     = '0;
`endif

endmodule

// File: tb/tb_hamming_secded_stream.sv
// Randomised scoreboard bench for hamming_secded_stream (P_BITS=3, CNT_W=2).
// Expected results come from encoding data and injecting known bit flips.
module tb_hamming_secded_stream;

  localparam int CNT_W = 2;
  localparam int CMAX  = 3;
`ifdef HAMMING_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] data;
    logic [2:0] syn;
    logic       corr;
    logic       unc;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_code;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_data;
  logic [2:0]       out_syndrome;
  logic             out_corrected;
  logic             out_uncorrectable;
  logic             cnt_clear;
  logic [CNT_W-1:0] cnt_corr;
  logic [CNT_W-1:0] cnt_uncorr;

  int   total = 0;
  int   bad   = 0;
  int   dpos[4] = '{3, 5, 6, 7};
  exp_t curExp;
  exp_t q[$];
  exp_t monE;
  int   cm = 0;
  int   um = 0;
  logic popCorr;
  logic popUnc;

  hamming_secded_stream #(.P_BITS(3), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_code           (in_code),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_syndrome      (out_syndrome),
    .out_corrected     (out_corrected),
    .out_uncorrectable (out_uncorrectable),
    .cnt_clear         (cnt_clear),
    .cnt_corr          (cnt_corr),
    .cnt_uncorr        (cnt_uncorr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] d, input logic [2:0] s, input logic c, input logic u);
    exp_t e;
    e.data = d; e.syn = s; e.corr = c; e.unc = u;
    return e;
  endfunction

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    c = '0;
    for (int i = 0; i < 4; i++) c[dpos[i]] = d[i];
    for (int j = 0; j < 3; j++) begin
      logic p;
      p = 1'b0;
      for (int pos = 1; pos < 8; pos++)
        if (pos[j] && pos != (1 << j)) p ^= c[pos];
      c[1 << j] = p;
    end
    c[0] = ^c[7:1];
    return c;
  endfunction

  function automatic logic [3:0] extract(input logic [7:0] c);
    logic [3:0] d;
    for (int i = 0; i < 4; i++) d[i] = c[dpos[i]];
    return d;
  endfunction

  task automatic genRandom(input int nerr, output logic [7:0] code, output exp_t e);
    logic [3:0] d;
    int p1, p2;
    d    = 4'($urandom_range(0, 15));
    code = encode(d);
    p1   = $urandom_range(0, 7);
    p2   = (p1 + $urandom_range(1, 7)) % 8;
    if (nerr == 0) begin
      e = mk(d, 3'd0, 1'b0, 1'b0);
    end else if (nerr == 1) begin
      code[p1] = ~code[p1];
      e = mk(d, 3'(p1), 1'b1, 1'b0);
    end else begin
      code[p1] = ~code[p1];
      code[p2] = ~code[p2];
      e = mk(extract(code), 3'(p1 ^ p2), 1'b0, 1'b1);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] code, input exp_t e);
    in_code = code;
    curExp  = e;
  endtask

  task automatic makeRandom(input int nerr);
    logic [7:0] c;
    exp_t e;
    genRandom(nerr, c, e);
    applyStimulus(c, e);
  endtask

  task automatic sendWord();
    bit ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) break;
    end
    @(posedge clk); #1;
    checkOutput("drain_empty", 32'(q.size()), 32'd0);
  endtask

  task automatic runDirected(input logic [7:0] code, input exp_t e, input int ecCorr, input int ecUnc);
    out_ready = 1'b1;
    applyStimulus(code, e);
    sendWord();
    checkOutput("lat_s1_only", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    checkOutput("lat_valid", 32'(out_valid), 32'd1);
    checkOutput("dir_data", 32'(out_data), 32'(e.data));
    checkOutput("dir_syn", 32'(out_syndrome), 32'(e.syn));
    checkOutput("dir_corr", 32'(out_corrected), 32'(e.corr));
    checkOutput("dir_unc", 32'(out_uncorrectable), 32'(e.unc));
    @(posedge clk); #1;
    checkOutput("dir_cnt_corr", 32'(cnt_corr), CNT_EN ? 32'(ecCorr) : 32'd0);
    checkOutput("dir_cnt_unc", 32'(cnt_uncorr), CNT_EN ? 32'(ecUnc) : 32'd0);
  endtask

  // Scoreboard: push on input handshake, compare on output handshake, model counters.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      cm = 0;
      um = 0;
    end else begin
      checkOutput("mon_cnt_corr", 32'(cnt_corr), CNT_EN ? 32'(cm) : 32'd0);
      checkOutput("mon_cnt_unc", 32'(cnt_uncorr), CNT_EN ? 32'(um) : 32'd0);
      popCorr = 1'b0;
      popUnc  = 1'b0;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checkOutput("out_without_input", 32'(out_valid), 32'd0);
        end else begin
          monE = q.pop_front();
          checkOutput("sb_data", 32'(out_data), 32'(monE.data));
          checkOutput("sb_syn", 32'(out_syndrome), 32'(monE.syn));
          checkOutput("sb_corr", 32'(out_corrected), 32'(monE.corr));
          checkOutput("sb_unc", 32'(out_uncorrectable), 32'(monE.unc));
          popCorr = monE.corr;
          popUnc  = monE.unc;
        end
      end
      if (in_valid && in_ready) q.push_back(curExp);
      if (cnt_clear) begin
        cm = 0;
        um = 0;
      end else begin
        if (popCorr && cm < CMAX) cm++;
        if (popUnc && um < CMAX) um++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] w[4];
    exp_t       we[4];

    rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b0; cnt_clear = 1'b0;
    curExp = '0;
    #2;
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_out_syn", 32'(out_syndrome), 32'd0);
    checkOutput("rst_flags", 32'({out_corrected, out_uncorrectable}), 32'd0);
    checkOutput("rst_cnts", 32'({cnt_corr, cnt_uncorr}), 32'd0);

    $display("[TB] directed vectors");
    runDirected(8'hAA, mk(4'b1011, 3'd0, 1'b0, 1'b0), 0, 0);
    runDirected(8'hEA, mk(4'b1011, 3'd6, 1'b1, 1'b0), 1, 0);
    runDirected(8'hAB, mk(4'b1011, 3'd0, 1'b1, 1'b0), 2, 0);
    runDirected(8'hAC, mk(4'b1011, 3'd3, 1'b0, 1'b1), 2, 1);

    $display("[TB] backpressure");
    w[0] = 8'hAA; we[0] = mk(4'b1011, 3'd0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) genRandom(i - 1, w[i], we[i]);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(w[i], we[i]);
      sendWord();
    end
    applyStimulus(w[2], we[2]);
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_hold_data", 32'(out_data), 32'(we[0].data));
    checkOutput("bp_hold_syn", 32'(out_syndrome), 32'(we[0].syn));
    out_ready = 1'b1;
    sendWord();
    applyStimulus(w[3], we[3]);
    sendWord();
    drain();

    $display("[TB] random stream");
    for (int cyc = 0; cyc < 400; cyc++) begin
      makeRandom($urandom_range(0, 2));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cnt_clear = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
    end
    cnt_clear = 1'b0;
    drain();

    $display("[TB] counter saturation");
    cnt_clear = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    for (int i = 0; i < 5; i++) begin
      makeRandom(1);
      sendWord();
    end
    drain();
    checkOutput("sat_cnt_corr", 32'(cnt_corr), CNT_EN ? 32'd3 : 32'd0);

    $display("[TB] clear coincident with handshake");
    out_ready = 1'b0;
    makeRandom(1);
    sendWord();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    @(posedge clk); #1;
    checkOutput("clr_pre_valid", 32'(out_valid), 32'd1);
    cnt_clear = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    cnt_clear = 1'b0;
    checkOutput("clr_coincident", 32'(cnt_corr), 32'd0);
    drain();

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    makeRandom(0);
    sendWord();
    makeRandom(1);
    sendWord();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      checkOutput("rst_no_output", 32'(out_valid), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
